servo_setpoint_bank: RTL

- Parametrised multi-channel successor to the single load-enable hold register used in the servo path.
- Holds one target setpoint per servo channel, loaded by a load strobe with channel select.
- Each channel's output slews toward its target by at most STEP per update tick, which limits mechanical jerk.
- Sits between the command decoder and the per-channel PWM generators; each PWM generator consumes one output word.

---
 rtl/servo_pkg.sv | 17 +
 rtl/servo_slew_channel.sv | 70 +++++++
 rtl/servo_setpoint_bank.sv | 74 +++++++
 3 files changed

// File: rtl/servo_pkg.sv
// servo_pkg
//   Shared defaults and helpers for the servo setpoint bank.
//   DEF_*      : default parameter values for servo_setpoint_bank
//   sel_width  : channel-select width for a given channel count (never below 1)
package servo_pkg;

  localparam int DEF_WIDTH    = 20;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_STEP     = 16;
  localparam int DEF_TICK_DIV = 1000;

  // A single channel still needs a one-bit select port.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/servo_slew_channel.sv
// servo_slew_channel
//   One servo channel: holds a target setpoint and an output that slews
//   toward it by at most STEP on each tick.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture din as the new target (output keeps slewing)
//   snap      : capture din as both target and output; beats load and tick
//   tick      : slew-update strobe
//   din       : setpoint data
//   out       : current output word
//   settled   : registered out == target
module servo_slew_channel #(
  parameter int WIDTH = 20,
  parameter int STEP  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             snap,
  input  logic             tick,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] out,
  output logic             settled
);

  localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);

  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             settled_q;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   mag;

  always_comb begin
    // One extra bit so the sign of target - out is never lost.
    diff     = {1'b0, target_q} - {1'b0, out_q};
    mag      = diff[WIDTH] ? ({1'b0, out_q} - {1'b0, target_q}) : diff;
    target_d = target_q;
    out_d    = out_q;
    if (snap) begin
      target_d = din;
      out_d    = din;
    end else begin
      if (load) target_d = din;
      // The step is taken against the pre-edge target, so a load landing on
      // a tick edge only steers the following ticks.
      if (tick) begin
        if (mag <= STEP_W)      out_d = target_q;
        else if (!diff[WIDTH])  out_d = out_q + STEP_N;
        else                    out_d = out_q - STEP_N;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q  <= '0;
      out_q     <= '0;
      settled_q <= 1'b1;
    end else begin
      target_q  <= target_d;
      out_q     <= out_d;
      settled_q <= (out_d == target_d);
    end
  end

  assign out     = out_q;
  assign settled = settled_q;

endmodule

// File: rtl/servo_setpoint_bank.sv
// servo_setpoint_bank
//   Multi-channel slew-limited setpoint holder feeding the PWM generators.
//   clk, rst : clock, asynchronous active-high reset
//   in       : setpoint data
//   ch_sel   : channel addressed by leer/snap (values >= CHANNELS ignored)
//   leer     : load in as target[ch_sel]
//   snap     : load in as target[ch_sel] and out[ch_sel] at once
//   out      : channel i in bits [i*WIDTH +: WIDTH]
//   settled  : bit i set when channel i output equals its target
//   tick     : one-cycle pulse every TICK_DIV cycles, drives the slew
module servo_setpoint_bank
  import servo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int STEP     = DEF_STEP,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          in,
  input  logic [SEL_W-1:0]          ch_sel,
  input  logic                      leer,
  input  logic                      snap,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic [CHANNELS-1:0]       settled,
  output logic                      tick
);

  localparam int              CNT_W    = (TICK_DIV <= 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == CNT_LAST);
    cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // An out-of-range select matches no channel, so it changes nothing.
    logic hit;
    assign hit = (ch_sel == SEL_W'(i));

    servo_slew_channel #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .load    (leer & hit),
      .snap    (snap & hit),
      .tick    (tick_q),
      .din     (in),
      .out     (out[i*WIDTH +: WIDTH]),
      .settled (settled[i])
    );
  end

endmodule
